// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide path: E-stage op codes,
// datapath operation select encoding and default latencies. Also used by the
// decoder and the MD datapath.
package md_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        SEL_MULT  = 2'd0,
        SEL_MULTU = 2'd1,
        SEL_DIV   = 2'd2,
        SEL_DIVU  = 2'd3
    } md_sel_e;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    // True for the four ops that occupy the datapath for a fixed latency.
    function automatic logic is_md_arith(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

    // True for the two ops that take the long (divide) latency.
    function automatic logic is_md_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Datapath select for an arithmetic op; non-arithmetic ops map to 0.
    function automatic logic [1:0] op_sel_of(input logic [3:0] op);
        logic [1:0] sel;
        case (op)
            OP_MULT:  sel = SEL_MULT;
            OP_MULTU: sel = SEL_MULTU;
            OP_DIV:   sel = SEL_DIV;
            OP_DIVU:  sel = SEL_DIVU;
            default:  sel = SEL_MULT;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/md_seq_ctrl.sv
// Sequencing controller for the HI/LO multiply/divide unit. Issues a start
// pulse for mult/div ops in E, times the fixed latency down to the HI/LO
// commit, drives mthi/mtlo write enables and stalls D while the unit is busy.
// An issued mult/div is never cancelled by irq; only reset discards it.
module md_seq_ctrl
    import md_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       irq,
    input  logic       e_valid,
    input  logic [3:0] e_op,
    input  logic       d_md_use,
    output logic       start,
    output logic [1:0] op_sel,
    output logic       hilo_we,
    output logic       hi_we,
    output logic       lo_we,
    output logic       busy,
    output logic       stall_d,
    output logic       proto_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             proto_err_q, proto_err_d;

    // State, latency counter and sticky protocol-error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Next state and combinational pulses; everything is forced low in reset.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        proto_err_d = proto_err_q;
        start       = 1'b0;
        op_sel      = 2'd0;
        hilo_we     = 1'b0;
        hi_we       = 1'b0;
        lo_we       = 1'b0;
        busy        = 1'b0;
        stall_d     = 1'b0;
        proto_err   = proto_err_q;

        case (state_q)
            ST_IDLE: begin
                if (e_valid && !irq) begin
                    if (is_md_arith(e_op)) begin
                        start   = 1'b1;
                        op_sel  = op_sel_of(e_op);
                        state_d = ST_RUN;
                        cnt_d   = is_md_div(e_op) ? DIV_CNT : MULT_CNT;
                    end else if (e_op == OP_MTHI) begin
                        hi_we = 1'b1;
                    end else if (e_op == OP_MTLO) begin
                        lo_we = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    hilo_we = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
                if (e_valid && (e_op != OP_NONE)) begin
                    proto_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (reset) begin
            start     = 1'b0;
            op_sel    = 2'd0;
            hilo_we   = 1'b0;
            hi_we     = 1'b0;
            lo_we     = 1'b0;
            busy      = 1'b0;
            proto_err = 1'b0;
        end

        stall_d = d_md_use && (busy || start);
    end

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Directed bench for md_seq_ctrl: a table of single-cycle IDLE vectors plus
// hand-written multi-cycle sequences for latency, irq, reset and protocol
// corner cases.
module tb_md_seq_ctrl;
    import md_pkg::*;

    localparam int MLAT = 5;
    localparam int DLAT = 10;

    logic       clk;
    logic       reset;
    logic       irq;
    logic       e_valid;
    logic [3:0] e_op;
    logic       d_md_use;
    logic       start;
    logic [1:0] op_sel;
    logic       hilo_we;
    logic       hi_we;
    logic       lo_we;
    logic       busy;
    logic       stall_d;
    logic       proto_err;

    int checks;
    int failures;

    typedef struct {
        logic       v;
        logic [3:0] op;
        logic       irq;
        logic       md;
        logic       exp_start;
        logic [1:0] exp_sel;
        logic       exp_hi;
        logic       exp_lo;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[12];

    md_seq_ctrl #(.MULT_LAT(MLAT), .DIV_LAT(DLAT), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq       (irq),
        .e_valid   (e_valid),
        .e_op      (e_op),
        .d_md_use  (d_md_use),
        .start     (start),
        .op_sel    (op_sel),
        .hilo_we   (hilo_we),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .busy      (busy),
        .stall_d   (stall_d),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [3:0] op,
                                 input logic i, input logic md);
        e_valid  = v;
        e_op     = op;
        irq      = i;
        d_md_use = md;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //          v  op        irq md  start sel hi lo stall
        vecs[0]  = '{1'b0, OP_NONE,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, OP_MULT,  1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, OP_MULTU, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, OP_DIV,   1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, OP_DIVU,  1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, OP_MULT,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, OP_MTHI,  1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, OP_MTLO,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, OP_MTHI,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, OP_MFHI,  1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, OP_DIV,   1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, OP_NONE,  1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};

        // Reset with an issuable op presented: nothing may leak out.
        reset = 1'b1;
        applyStimulus(1'b1, OP_MULT, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2;
        checkOutput("rst_start", start, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_stall", stall_d, 0);
        reset = 1'b0;
        applyStimulus(1'b0, OP_NONE, 1'b0, 0);
        @(negedge clk);
        #2;
        checkOutput("post_rst_outs", {start, op_sel, hilo_we, hi_we, lo_we, busy, stall_d, proto_err}, 0);

        // Table: one IDLE vector, then the following cycle's busy, then reset.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].v, vecs[i].op, vecs[i].irq, vecs[i].md);
            #2;
            checkOutput($sformatf("vec%0d_start", i), start, vecs[i].exp_start);
            checkOutput($sformatf("vec%0d_hi_we", i), hi_we, vecs[i].exp_hi);
            checkOutput($sformatf("vec%0d_lo_we", i), lo_we, vecs[i].exp_lo);
            checkOutput($sformatf("vec%0d_stall", i), stall_d, vecs[i].exp_stall);
            checkOutput($sformatf("vec%0d_hilo_we", i), hilo_we, 0);
            if (vecs[i].exp_start)
                checkOutput($sformatf("vec%0d_op_sel", i), op_sel, vecs[i].exp_sel);
            @(negedge clk);
            applyStimulus(1'b0, OP_NONE, 1'b0, 1'b0);
            #2;
            checkOutput($sformatf("vec%0d_busy_next", i), busy, vecs[i].exp_start);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end

        // MULT: commit exactly MLAT cycles after start.
        @(negedge clk);
        applyStimulus(1'b1, OP_MULT, 1'b0, 1'b0);
        #2;
        checkOutput("mult_start", start, 1);
        checkOutput("mult_op_sel", op_sel, 0);
        for (int k = 1; k <= MLAT + 1; k++) begin
            @(negedge clk);
            applyStimulus(1'b0, OP_NONE, 1'b0, 1'b0);
            #2;
            checkOutput($sformatf("mult_busy_t%0d", k), busy, (k <= MLAT));
            checkOutput($sformatf("mult_hilo_t%0d", k), hilo_we, (k == MLAT));
            checkOutput($sformatf("mult_start_t%0d", k), start, 0);
        end

        // DIVU with an MD op held in D: stall from issue through commit.
        @(negedge clk);
        applyStimulus(1'b1, OP_DIVU, 1'b0, 1'b1);
        #2;
        checkOutput("divu_start", start, 1);
        checkOutput("divu_op_sel", op_sel, 3);
        checkOutput("divu_stall_t0", stall_d, 1);
        for (int k = 1; k <= DLAT + 1; k++) begin
            @(negedge clk);
            applyStimulus(1'b0, OP_NONE, 1'b0, 1'b1);
            #2;
            checkOutput($sformatf("divu_stall_t%0d", k), stall_d, (k <= DLAT));
            checkOutput($sformatf("divu_hilo_t%0d", k), hilo_we, (k == DLAT));
        end

        // MULT blocked by irq: no start, nothing in flight afterwards.
        @(negedge clk);
        applyStimulus(1'b1, OP_MULT, 1'b1, 1'b0);
        #2;
        checkOutput("irq_mult_start", start, 0);
        @(negedge clk);
        applyStimulus(1'b0, OP_NONE, 1'b0, 1'b0);
        #2;
        checkOutput("irq_mult_busy", busy, 0);
        checkOutput("irq_mult_hilo", hilo_we, 0);

        // irq during a running DIV does not cancel it.
        @(negedge clk);
        applyStimulus(1'b1, OP_DIV, 1'b0, 1'b0);
        #2;
        checkOutput("div_start", start, 1);
        checkOutput("div_op_sel", op_sel, 2);
        for (int k = 1; k <= DLAT + 1; k++) begin
            @(negedge clk);
            applyStimulus(1'b0, OP_NONE, (k == 2), 1'b0);
            #2;
            checkOutput($sformatf("div_irq_busy_t%0d", k), busy, (k <= DLAT));
            checkOutput($sformatf("div_irq_hilo_t%0d", k), hilo_we, (k == DLAT));
        end

        // Reset in the middle of a MULT discards the result.
        @(negedge clk);
        applyStimulus(1'b1, OP_MULT, 1'b0, 1'b1);
        #2;
        checkOutput("rstmid_start", start, 1);
        for (int k = 1; k <= MLAT + 1; k++) begin
            @(negedge clk);
            reset = (k == 3);
            applyStimulus(1'b0, OP_NONE, 1'b0, 1'b1);
            #2;
            checkOutput($sformatf("rstmid_busy_t%0d", k), busy, (k < 3));
            checkOutput($sformatf("rstmid_stall_t%0d", k), stall_d, (k < 3));
            checkOutput($sformatf("rstmid_hilo_t%0d", k), hilo_we, 0);
        end
        reset = 1'b0;
        checkOutput("rstmid_proto_err", proto_err, 0);

        // MD ops reaching E while busy: sticky error, ops ignored.
        @(negedge clk);
        applyStimulus(1'b1, OP_MULT, 1'b0, 1'b0);
        #2;
        checkOutput("proto_issue_start", start, 1);
        for (int k = 1; k <= MLAT + 3; k++) begin
            @(negedge clk);
            case (k)
                2:       applyStimulus(1'b1, OP_MFLO, 1'b0, 1'b0);
                3:       applyStimulus(1'b1, OP_MTHI, 1'b0, 1'b0);
                4:       applyStimulus(1'b1, OP_MULT, 1'b0, 1'b0);
                default: applyStimulus(1'b0, OP_NONE, 1'b0, 1'b0);
            endcase
            #2;
            checkOutput($sformatf("proto_err_t%0d", k), proto_err, (k >= 3));
            checkOutput($sformatf("proto_start_t%0d", k), start, 0);
            checkOutput($sformatf("proto_hi_lo_t%0d", k), {hi_we, lo_we}, 0);
            checkOutput($sformatf("proto_hilo_t%0d", k), hilo_we, (k == MLAT));
            checkOutput($sformatf("proto_busy_t%0d", k), busy, (k <= MLAT));
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #2;
        checkOutput("proto_err_cleared", proto_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
